reg_bank_wb: RTL and testbench
==============================

REG_BANK_WB -- requirements
Module: reg_bank_wb

Interface
REQ-001 Parameters SHALL be NREG = 8 (register count), AW = 3 (address width), DW = 8 (data width).
REQ-002 Ports SHALL be:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- wb_valid, input, 1: writeback request present this cycle.
- wb_addr, input, AW: destination register index.
- wb_data, input, DW: write data.
- stall, input, 1: hold the pending entry; no commit.
- flush, input, 1: discard the pending entry and the incoming request.
- rd_addr_a, input, AW: read port A index.
- rd_addr_b, input, AW: read port B index.
- rd_data_a, output, DW: port A data, forwarded.
- rd_data_b, output, DW: port B data, forwarded.
- wr_onehot, output, NREG: one-hot write select of the pending entry; all zero when there is no valid pending entry.
- commit, output, 1: the pending entry is written at this clock edge.
REQ-003 Clock SHALL be clk only; reset SHALL be rst_n, synchronous, active-low.

Function
REQ-004 The block SHALL hold one pending-write stage (pend_valid, pend_addr, pend_data) and NREG x DW storage registers.
REQ-005 Capture: on an edge with rst_n=1, flush=0, stall=0, the stage SHALL load pend_valid<=wb_valid, pend_addr<=wb_addr, pend_data<=wb_data.
REQ-006 Commit: commit SHALL equal pend_valid & ~stall & ~flush, decoded combinationally from registered state plus the stall and flush inputs.
REQ-007 On an edge where commit=1, register[pend_addr] SHALL take pend_data; every other register SHALL hold its value.
REQ-008 Latency: a request presented at cycle N SHALL be visible in storage after the edge ending cycle N+1, given no stall or flush.
REQ-009 wr_onehot SHALL be 1<<pend_addr when pend_valid=1, else 0; it SHALL not be gated by stall.
REQ-010 Stall: while stall=1 and flush=0, the pending stage and storage SHALL hold and wb_* SHALL be ignored; the upstream stage holds its request.
REQ-011 Flush: on an edge with flush=1, pend_valid SHALL clear, nothing SHALL commit, and wb_* SHALL be ignored; flush SHALL take priority over stall.
REQ-012 Back-to-back same address: consecutive commits SHALL apply in order, and the last one wins.
REQ-013 Reads SHALL be combinational: rd_data_x = pend_data when pend_valid=1 and pend_addr==rd_addr_x, else register[rd_addr_x].
REQ-014 Forwarding SHALL apply during stall, since the pending data is still architecturally next, and SHALL not apply after flush clears pend_valid.
REQ-015 Both read ports SHALL be independent; the same address on both SHALL return identical data.
REQ-016 Register 0 SHALL be an ordinary writable register; there is no hardwired zero.

Reset
REQ-017 On an edge with rst_n=0, all NREG registers SHALL become 8'h00 and pend_valid, pend_addr, pend_data SHALL become 0.
REQ-018 During reset, commit=0 and wr_onehot=8'h00; rd_data_x SHALL read 8'h00 from the cycle after the reset edge.
REQ-019 Reset SHALL override stall, flush and wb_valid; a pending entry at reset SHALL be dropped and never written.

Structure
REQ-020 NREG, AW, DW and the reset data value SHALL live in a shared package used by the decode and datapath blocks.
REQ-021 The address-to-one-hot decode SHALL be one sub-module, reg_sel_decoder (inputs addr[AW-1:0] and en; output one-hot [NREG-1:0]), instantiated with en=pend_valid.
REQ-022 Commit SHALL gate the per-register write enables; there SHALL be no other sub-modules.

Verification
REQ-023 Basic write: reset, then wb_valid=1, addr=3, data=8'hA5 at cycle 0 -> wr_onehot=8'h08 and commit=1 in cycle 1; register 3 reads 8'hA5 from cycle 2.
REQ-024 Forwarding: pending addr=5, data=8'h3C with rd_addr_a=5 -> rd_data_a=8'h3C in the same cycle, before commit; rd_addr_b=4 returns the stored register 4 value.
REQ-025 Stall: pending addr=7, data=8'h11 with stall=1 for 3 cycles and new wb requests offered -> commit=0, wr_onehot=8'h80 held, rd 7 forwards 8'h11; 8'h11 commits on the first unstalled edge and the stalled-cycle requests never commit.
REQ-026 Flush with stall: pending addr=2, data=8'hFF with flush=1 and stall=1 -> commit=0; register 2 keeps its old value; next cycle pend_valid=0 and wr_onehot=8'h00.
REQ-027 Back-to-back: addr=1 with data 8'h01, 8'h02, 8'h03 on consecutive cycles -> three commits; register 1 reads 8'h03; port A tracks the forwarded value each cycle.
REQ-028 Mid-operation reset: rst_n=0 while pending addr=6, data=8'h77 -> all registers 8'h00 and no commit of 8'h77.

Source files
------------

// File: rtl/reg_bank_wb_pkg.sv
// Shared sizing and types for the writeback register bank: register count,
// address/data widths and the value storage takes on reset.
package reg_bank_wb_pkg;

    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = 3;
    localparam int unsigned DW   = 8;

    localparam logic [DW-1:0] RST_DATA = '0;

    typedef logic [AW-1:0]   addr_t;
    typedef logic [DW-1:0]   data_t;
    typedef logic [NREG-1:0] sel_t;

endpackage

// File: rtl/reg_bank_wb_reg_sel_decoder.sv
// Address to one-hot register select; all zero when en is low.
module reg_sel_decoder
    import reg_bank_wb_pkg::*;
(
    input  logic [AW-1:0]   addr,
    input  logic            en,
    output logic [NREG-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_wb.sv
// Register bank behind a single pending-write stage, with read ports that
// forward the pending entry so consumers always see the architecturally next value.
module reg_bank_wb
    import reg_bank_wb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [DW-1:0]   wb_data,
    input  logic            stall,
    input  logic            flush,
    input  logic [AW-1:0]   rd_addr_a,
    input  logic [AW-1:0]   rd_addr_b,
    output logic [DW-1:0]   rd_data_a,
    output logic [DW-1:0]   rd_data_b,
    output logic [NREG-1:0] wr_onehot,
    output logic            commit
);

    logic  pend_valid_q, pend_valid_d;
    addr_t pend_addr_q, pend_addr_d;
    data_t pend_data_q, pend_data_d;
    data_t regs_q [NREG];
    data_t regs_d [NREG];

    sel_t  pend_sel;
    sel_t  reg_we;

    reg_sel_decoder u_sel_dec (
        .addr   (pend_addr_q),
        .en     (pend_valid_q),
        .onehot (pend_sel)
    );

    // Reset masks both outputs so a pending entry caught by reset never looks live.
    assign commit    = rst_n & pend_valid_q & ~stall & ~flush;
    assign wr_onehot = rst_n ? pend_sel : '0;
    assign reg_we    = pend_sel & {NREG{commit}};

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        if (flush) begin
            pend_valid_d = 1'b0;
        end else if (!stall) begin
            pend_valid_d = wb_valid;
            pend_addr_d  = wb_addr;
            pend_data_d  = wb_data;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_d[i] = reg_we[i] ? pend_data_q : regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= RST_DATA;
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= RST_DATA;
            end
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            regs_q       <= regs_d;
        end
    end

    always_comb begin
        if (pend_valid_q && (pend_addr_q == rd_addr_a)) begin
            rd_data_a = pend_data_q;
        end else begin
            rd_data_a = regs_q[rd_addr_a];
        end
        if (pend_valid_q && (pend_addr_q == rd_addr_b)) begin
            rd_data_b = pend_data_q;
        end else begin
            rd_data_b = regs_q[rd_addr_b];
        end
    end

endmodule

// File: tb/tb_reg_bank_wb.sv
// Scoreboard bench for reg_bank_wb: directed scenarios followed by random traffic,
// checked against an array-based model of the pending stage and storage.
module tb_reg_bank_wb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wb_valid;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic       stall;
    logic       flush;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic [7:0] rd_data_a;
    logic [7:0] rd_data_b;
    logic [7:0] wr_onehot;
    logic       commit;

    always #5 clk = ~clk;

    reg_bank_wb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .stall     (stall),
        .flush     (flush),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_onehot (wr_onehot),
        .commit    (commit)
    );

    typedef struct {
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] oh;
        logic       cm;
        logic       chk_oh;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model: architectural registers plus the one queued write.
    logic [7:0] mem [8];
    logic       m_pv;
    logic [2:0] m_pa;
    logic [7:0] m_pd;
    logic       model_ok = 1'b0;

    task automatic check(input string name, input int c, input logic [7:0] act,
                         input logic [7:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle %0d: got %h required %h", name, c, act, req);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_data_a", e.cyc, rd_data_a, e.ra);
                check("rd_data_b", e.cyc, rd_data_b, e.rb);
                check("commit", e.cyc, {7'b0, commit}, {7'b0, e.cm});
                if (e.chk_oh) check("wr_onehot", e.cyc, wr_onehot, e.oh);
            end
        end
    end

    function automatic logic [7:0] model_read(input logic [2:0] a);
        if (m_pv && m_pa == a) return m_pd;
        return mem[a];
    endfunction

    // Drive one cycle, predict this cycle's outputs, then advance the model.
    task automatic step(input logic r, input logic v, input logic [2:0] a,
                        input logic [7:0] d, input logic s, input logic f,
                        input logic [2:0] ra, input logic [2:0] rb);
        exp_t e;
        logic cm;
        rst_n = r; wb_valid = v; wb_addr = a; wb_data = d;
        stall = s; flush = f; rd_addr_a = ra; rd_addr_b = rb;
        if (model_ok) begin
            cm       = r && m_pv && !s && !f;
            e.ra     = model_read(ra);
            e.rb     = model_read(rb);
            e.cm     = cm;
            e.oh     = m_pv ? (8'h01 << m_pa) : 8'h00;
            e.chk_oh = r;
            e.cyc    = cyc;
            exp_q.push_back(e);
            if (r && cm) mem[m_pa] = m_pd;
        end
        if (!r) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'h00;
            m_pv = 1'b0; m_pa = 3'd0; m_pd = 8'h00;
            model_ok = 1'b1;
        end else if (f) begin
            m_pv = 1'b0;
        end else if (!s) begin
            m_pv = v; m_pa = a; m_pd = d;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin : stim
        rst_n = 1'b0; wb_valid = 1'b0; wb_addr = 3'd0; wb_data = 8'h00;
        stall = 1'b0; flush = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        @(posedge clk);
        #1;
        step(0, 1, 3'd4, 8'hEE, 1, 1, 3'd0, 3'd0);
        step(0, 0, 3'd0, 8'h00, 0, 0, 3'd3, 3'd7);
        // Basic write to register 3
        step(1, 1, 3'd3, 8'hA5, 0, 0, 3'd3, 3'd0);
        step(1, 0, 3'd0, 8'h00, 0, 0, 3'd3, 3'd3);
        step(1, 0, 3'd0, 8'h00, 0, 0, 3'd3, 3'd4);
        // Seed register 4, then forward a pending write to 5
        step(1, 1, 3'd4, 8'h44, 0, 0, 3'd4, 3'd4);
        step(1, 1, 3'd5, 8'h3C, 0, 0, 3'd4, 3'd5);
        step(1, 0, 3'd0, 8'h00, 0, 0, 3'd5, 3'd4);
        // Pending 7/11 held through three stalled cycles with new requests offered
        step(1, 1, 3'd7, 8'h11, 0, 0, 3'd7, 3'd0);
        for (int i = 0; i < 3; i++) step(1, 1, 3'd7, 8'h99, 1, 0, 3'd7, 3'd6);
        step(1, 0, 3'd0, 8'h00, 0, 0, 3'd7, 3'd7);
        step(1, 0, 3'd0, 8'h00, 0, 0, 3'd7, 3'd7);
        // Flush with stall drops pending 2/FF
        step(1, 1, 3'd2, 8'h42, 0, 0, 3'd2, 3'd2);
        step(1, 1, 3'd2, 8'hFF, 0, 0, 3'd2, 3'd2);
        step(1, 1, 3'd1, 8'h55, 1, 1, 3'd2, 3'd1);
        step(1, 0, 3'd0, 8'h00, 0, 0, 3'd2, 3'd1);
        // Back-to-back writes to register 1
        step(1, 1, 3'd1, 8'h01, 0, 0, 3'd1, 3'd0);
        step(1, 1, 3'd1, 8'h02, 0, 0, 3'd1, 3'd0);
        step(1, 1, 3'd1, 8'h03, 0, 0, 3'd1, 3'd0);
        step(1, 0, 3'd0, 8'h00, 0, 0, 3'd1, 3'd1);
        step(1, 0, 3'd0, 8'h00, 0, 0, 3'd1, 3'd0);
        // Register 0 is writable
        step(1, 1, 3'd0, 8'hC3, 0, 0, 3'd0, 3'd0);
        step(1, 0, 3'd0, 8'h00, 0, 0, 3'd0, 3'd0);
        // Reset while 6/77 is pending
        step(1, 1, 3'd6, 8'h77, 0, 0, 3'd6, 3'd6);
        step(0, 1, 3'd5, 8'h12, 1, 0, 3'd6, 3'd6);
        for (int i = 0; i < 8; i++) step(1, 0, 3'd0, 8'h00, 0, 0, 3'(i), 3'(7 - i));
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) != 0), $urandom_range(0, 1),
                 3'($urandom_range(0, 7)), 8'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        step(1, 0, 3'd0, 8'h00, 0, 0, 3'd0, 3'd1);
        for (int i = 0; i < 8; i++) step(1, 0, 3'd0, 8'h00, 0, 0, 3'(i), 3'(i));
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
